// File: rtl/frame_packer_pkg.sv
// Shared constants, header layout and FSM encodings for the frame packer.
// Also provides the channel-walk helper used by the top.
package frame_packer_pkg;

    localparam logic [31:0] MAGIC_DEFAULT = 32'hF0AA550F;
    localparam int unsigned HDR_WORDS     = 4;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned MAX_CHN       = 8;

    localparam int unsigned W2_HLEN_LSB    = 0;
    localparam int unsigned W2_MASK_LSB    = 8;
    localparam int unsigned W2_PAYLOAD_LSB = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Lowest set channel at or above 'from'; bit 3 set means none left.
    function automatic logic [3:0] next_chn(input logic [MAX_CHN-1:0] mask,
                                            input int unsigned from);
        logic [3:0] res;
        res = 4'h8;
        for (int unsigned n = MAX_CHN; n > 0; n--) begin
            if (mask[n-1] && ((n - 1) >= from)) begin
                res = 4'(n - 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_packer_if.sv
// Valid/ready output word stream from the frame packer to the host transport.
interface frame_packer_if;
    import frame_packer_pkg::*;

    logic [WORD_W-1:0] out_data;
    logic              out_vld;
    logic              out_rdy;

    modport master (output out_data, output out_vld, input out_rdy);
    modport slave  (input out_data, input out_vld, output out_rdy);

endinterface

// File: rtl/fp_skid_fifo.sv
// Two-entry output FIFO; head word is held stable until popped.
module fp_skid_fifo #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/frame_packer.sv
// Frame packer: snapshots channel counts on i_complite, emits a 4-word header,
// then streams every enabled non-empty channel buffer through a skid FIFO.
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int unsigned CHN_COUNT = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] MAGIC     = MAGIC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_complite,
    input  logic [CHN_COUNT-1:0]          i_chn_en,
    input  logic [CHN_COUNT*ADDR_W-1:0]   i_data_len,
    input  logic [31:0]                   i_timestamp,
    output logic [2:0]                    o_rd_chn,
    output logic [ADDR_W-1:0]             o_rd_addr,
    input  logic [CHN_COUNT*DATA_W-1:0]   i_rd_data,
    frame_packer_if.master                out_if,
    output logic                          o_frame_ready,
    output logic [15:0]                   o_frame_size,
    output logic                          o_frame_done,
    output logic                          o_overrun
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] eff_len_q [MAX_CHN];
    logic [MAX_CHN-1:0] mask_q;
    logic [31:0]       ts_q;
    logic [31:0]       frame_cnt_q;
    logic [15:0]       frame_size_q;
    logic              frame_ready_q;
    logic [1:0]        hdr_idx_q;
    logic [2:0]        chn_q;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic              inflight_hdr_q;
    logic [2:0]        inflight_idx_q;

    logic [MAX_CHN*ADDR_W-1:0] len_pad;
    logic [MAX_CHN*DATA_W-1:0] rd_pad;
    logic [MAX_CHN-1:0]        en_pad;
    logic [MAX_CHN-1:0]        mask_new;
    logic [ADDR_W-1:0]         len_new [MAX_CHN];
    logic [15:0]               payload_new;
    logic [3:0]                first_chn;
    logic [3:0]                nxt_chn;

    logic              vld, pop, push, can_issue, hdr_issue, dat_issue, last_addr, done;
    logic [2:0]        occ;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_data, push_data;
    logic [31:0]       w2, hdr_word;

    always_comb begin
        len_pad     = (MAX_CHN*ADDR_W)'(i_data_len);
        en_pad      = MAX_CHN'(i_chn_en);
        payload_new = '0;
        for (int unsigned k = 0; k < MAX_CHN; k++) begin
            len_new[k]  = en_pad[k] ? len_pad[k*ADDR_W +: ADDR_W] : '0;
            mask_new[k] = (len_new[k] != '0);
            payload_new = payload_new + 16'(len_new[k]);
        end
        first_chn = next_chn(mask_new, 0);
        nxt_chn   = next_chn(mask_q, 32'(chn_q) + 1);
    end

    // Header words and RAM reads share one issue slot; each lands in the FIFO
    // one cycle after issue, so the occupancy rule covers both uniformly.
    always_comb begin
        vld       = (fifo_count != 2'd0);
        pop       = vld && out_if.out_rdy;
        push      = inflight_q;
        occ       = 3'(fifo_count) + 3'(inflight_q);
        can_issue = (occ < (3'd2 + 3'(pop)));
        hdr_issue = (state_q == ST_HDR) && can_issue;
        dat_issue = (state_q == ST_DATA) && can_issue;
        last_addr = (addr_q == (eff_len_q[chn_q] - ADDR_W'(1)));
        done      = (state_q == ST_DRAIN) && pop && (fifo_count == 2'd1) && !inflight_q;
    end

    always_comb begin
        w2 = '0;
        w2[W2_PAYLOAD_LSB +: 16] = frame_size_q - 16'(HDR_WORDS);
        w2[W2_MASK_LSB +: 8]     = 8'(mask_q);
        w2[W2_HLEN_LSB +: 8]     = 8'(HDR_WORDS);
        case (inflight_idx_q[1:0])
            2'd0:    hdr_word = MAGIC;
            2'd1:    hdr_word = frame_cnt_q;
            2'd2:    hdr_word = w2;
            default: hdr_word = ts_q;
        endcase
        rd_pad    = (MAX_CHN*DATA_W)'(i_rd_data);
        push_data = inflight_hdr_q ? DATA_W'(hdr_word)
                                   : rd_pad[inflight_idx_q*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_complite) state_d = ST_HDR;
            ST_HDR:   if (hdr_issue && (hdr_idx_q == 2'd3))
                          state_d = (mask_q != '0) ? ST_DATA : ST_DRAIN;
            ST_DATA:  if (dat_issue && last_addr && nxt_chn[3]) state_d = ST_DRAIN;
            default:  if (done) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            for (int unsigned k = 0; k < MAX_CHN; k++) eff_len_q[k] <= '0;
            mask_q         <= '0;
            ts_q           <= '0;
            frame_cnt_q    <= '0;
            frame_size_q   <= '0;
            frame_ready_q  <= 1'b0;
            hdr_idx_q      <= '0;
            chn_q          <= '0;
            addr_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_hdr_q <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= hdr_issue || dat_issue;
            if (hdr_issue || dat_issue) begin
                inflight_hdr_q <= hdr_issue;
                inflight_idx_q <= hdr_issue ? {1'b0, hdr_idx_q} : chn_q;
            end
            case (state_q)
                ST_IDLE: if (i_complite) begin
                    for (int unsigned k = 0; k < MAX_CHN; k++) eff_len_q[k] <= len_new[k];
                    mask_q        <= mask_new;
                    ts_q          <= i_timestamp;
                    frame_size_q  <= payload_new + 16'(HDR_WORDS);
                    frame_ready_q <= 1'b1;
                    hdr_idx_q     <= '0;
                    chn_q         <= first_chn[2:0];
                    addr_q        <= '0;
                end
                ST_HDR: if (hdr_issue) hdr_idx_q <= hdr_idx_q + 2'd1;
                ST_DATA: if (dat_issue) begin
                    if (last_addr) begin
                        chn_q  <= nxt_chn[2:0];
                        addr_q <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if (push && inflight_hdr_q && (inflight_idx_q[1:0] == 2'd3)) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (done) frame_ready_q <= 1'b0;
        end
    end

    fp_skid_fifo #(.DATA_W(DATA_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .data_o      (fifo_data),
        .count_o     (fifo_count)
    );

    assign out_if.out_data = WORD_W'(fifo_data);
    assign out_if.out_vld  = vld;
    assign o_rd_chn        = chn_q;
    assign o_rd_addr       = addr_q;
    assign o_frame_ready   = frame_ready_q;
    assign o_frame_size    = frame_size_q;
    assign o_frame_done    = done;
    assign o_overrun       = i_complite && (state_q != ST_IDLE);

endmodule
